blink: RTL and testbench



---
 rtl/blink_pkg.sv | 39 +++
 rtl/blink_clock_divider.sv | 31 +++
 rtl/blink.sv | 81 ++++++++
 tb/tb_blink.sv | 137 +++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared step encoding, lamp patterns and 7-segment codes for the blink
// turn-signal / hazard generator.
package blink_pkg;

    typedef enum logic [1:0] {
        STEP_0 = 2'd0,
        STEP_1 = 2'd1,
        STEP_2 = 2'd2,
        STEP_3 = 2'd3
    } step_t;

    localparam logic [2:0] LAMPS_OFF = 3'b000;
    localparam logic [2:0] LAMPS_ON  = 3'b111;

    // Active-low segments, DP (bit 7) kept dark
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [2:0] step_pattern(input step_t step);
        return {step >= STEP_3, step >= STEP_2, step >= STEP_1};
    endfunction

    function automatic logic [7:0] step_seg(input step_t step);
        logic [7:0] seg;
        seg = SEG_0;
        unique case (step)
            STEP_0: seg = SEG_0;
            STEP_1: seg = SEG_1;
            STEP_2: seg = SEG_2;
            STEP_3: seg = SEG_3;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/blink_clock_divider.sv
// Modulo-DIVIDE_BY counter producing a one-cycle rate enable, with a
// synchronous clear so a sequence restart also restarts the timebase.
module clock_divider
    import blink_pkg::*;
#(
    parameter int DIVIDE_BY = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE_BY - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blink.sv
// Turn-signal / hazard lamp sequencer with optional 7-seg status digit.
// Define BLINK_HEX_EN to build the hex decoder; otherwise hex is blank.
module blink
    import blink_pkg::*;
#(
    parameter int DIVIDE_BY = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hazards,
    input  logic       turnChange,
    output logic [2:0] rightLEDs,
    output logic [2:0] leftLEDs,
    output logic [7:0] hex
);

    logic  r_prev_hazards;
    logic  r_prev_turn;
    step_t r_step;
    logic  r_phase;
    logic  [2:0] r_lamps;
    logic  w_restart;
    logic  w_tick;

    // Any edge on either mode input restarts the sequence from dark
    assign w_restart = (hazards != r_prev_hazards) ||
                       (turnChange != r_prev_turn);

    clock_divider #(
        .DIVIDE_BY (DIVIDE_BY),
        .CNT_W     (CNT_W)
    ) u_div (
        .clock (clock),
        .reset (reset),
        .clear (w_restart),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        r_prev_hazards <= hazards;
        r_prev_turn    <= turnChange;
        if (reset || w_restart) begin
            r_step  <= STEP_0;
            r_phase <= 1'b0;
            r_lamps <= LAMPS_OFF;
        end else begin
            r_lamps <= hazards ? (r_phase ? LAMPS_ON : LAMPS_OFF)
                               : step_pattern(r_step);
            if (w_tick) begin
                if (hazards) begin
                    r_phase <= ~r_phase;
                end else begin
                    r_step <= step_t'(r_step + 2'd1);
                end
            end
        end
    end

    assign leftLEDs  = r_lamps;
    assign rightLEDs = r_lamps;

`ifdef BLINK_HEX_EN
    logic [7:0] r_hex;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hex <= SEG_0;
        end else if (w_restart) begin
            r_hex <= hazards ? SEG_H : SEG_0;
        end else begin
            r_hex <= hazards ? SEG_H : step_seg(r_step);
        end
    end

    assign hex = r_hex;
`else
    assign hex = SEG_BLANK;
`endif

endmodule

// File: tb/tb_blink.sv
// Randomized check of blink at DIVIDE_BY=1 and DIVIDE_BY=4 against a
// tick-counting reference model.
module tb_blink;

    logic       clock = 1'b0;
    logic       reset;
    logic       hazards;
    logic       turnChange;
    logic [2:0] l1, r1, l4, r4;
    logic [7:0] h1, h4;

    int checks = 0;
    int errors = 0;

    int         cyc_since[2];
    int         div_by[2] = '{1, 4};
    logic       p_hz, p_tn;
    logic [2:0] exp_lamps[2];
    logic [7:0] exp_hex[2];

    always #5 clock = ~clock;

    blink #(.DIVIDE_BY(1), .CNT_W(20)) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .hazards    (hazards),
        .turnChange (turnChange),
        .rightLEDs  (r1),
        .leftLEDs   (l1),
        .hex        (h1)
    );

    blink #(.DIVIDE_BY(4), .CNT_W(20)) u_dut4 (
        .clock      (clock),
        .reset      (reset),
        .hazards    (hazards),
        .turnChange (turnChange),
        .rightLEDs  (r4),
        .leftLEDs   (l4),
        .hex        (h4)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] digit(input int s);
        case (s)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            default: return 8'hB0;
        endcase
    endfunction

    // Expected outputs after an edge: number of ticks seen before it
    task automatic model_edge();
        logic restart;
        int   n;
        restart = (hazards != p_hz) || (turnChange != p_tn);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cyc_since[i] = 0;
                exp_lamps[i] = 3'b000;
                exp_hex[i]   = 8'hC0;
            end else if (restart) begin
                cyc_since[i] = 0;
                exp_lamps[i] = 3'b000;
                exp_hex[i]   = hazards ? 8'h89 : 8'hC0;
            end else begin
                cyc_since[i]++;
                n = (cyc_since[i] - 1) / div_by[i];
                if (hazards) begin
                    exp_lamps[i] = (n % 2 == 1) ? 3'b111 : 3'b000;
                    exp_hex[i]   = 8'h89;
                end else begin
                    exp_lamps[i] = 3'((1 << (n % 4)) - 1);
                    exp_hex[i]   = digit(n % 4);
                end
            end
`ifndef BLINK_HEX_EN
            exp_hex[i] = 8'hFF;
`endif
        end
        p_hz = hazards;
        p_tn = turnChange;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("left_d1",  {5'd0, l1}, {5'd0, exp_lamps[0]});
        check("right_d1", {5'd0, r1}, {5'd0, exp_lamps[0]});
        check("hex_d1",   h1,         exp_hex[0]);
        check("left_d4",  {5'd0, l4}, {5'd0, exp_lamps[1]});
        check("right_d4", {5'd0, r4}, {5'd0, exp_lamps[1]});
        check("hex_d4",   h4,         exp_hex[1]);
    endtask

    initial begin
        reset      = 1'b1;
        hazards    = 1'b0;
        turnChange = 1'b0;
        p_hz       = 1'b0;
        p_tn       = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (40) cyc();
        turnChange = 1'b1;
        repeat (10) cyc();
        hazards = 1'b1;
        repeat (40) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (10) cyc();
        hazards = 1'b0;
        repeat (20) cyc();
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom % 64) == 0;
            if (($urandom % 16) == 0) turnChange = ~turnChange;
            if (($urandom % 24) == 0) hazards = ~hazards;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
